mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single main-memory port between the instruction-fetch path and the data-cache
//  refill/write-back path of the pipelined core. Arbitrates, then sequences one fixed-latency
//  memory transaction at a time and returns a one-cycle ack with read data to the winner.
//  Sits between the core/cache and the memory model.
// PARAMETERS
//  ADDR_W        32  address width, both ports and memory
//  DATA_W        32  data word width
//  MEM_LATENCY   2   memory read latency in cycles, >=1; BUSY lasts exactly this long
//  STARVE_LIMIT  4   consecutive data grants, with fetch pending, before fetch is forced
// PORTS
//  clk          in   1       clock, rising edge
//  rst_b        in   1       asynchronous active-low reset
//  i_req        in   1       fetch read request; hold with i_addr stable until i_ack
//  i_addr       in   ADDR_W  fetch address
//  i_ack        out  1       one-cycle pulse; i_rdata valid this cycle
//  i_rdata      out  DATA_W  fetch read data
//  d_req        in   1       data request; hold with d_we/d_addr/d_wdata stable until d_ack
//  d_we         in   1       1 = write, 0 = read
//  d_addr       in   ADDR_W  data address
//  d_wdata      in   DATA_W  write data
//  d_ack        out  1       one-cycle pulse; d_rdata valid (reads) / write committed
//  d_rdata      out  DATA_W  data read data
//  mem_addr     out  ADDR_W  memory address
//  mem_wdata    out  DATA_W  memory write data
//  mem_write_en out  1       memory write strobe
//  mem_rdata    in   DATA_W  memory read data, valid MEM_LATENCY cycles after mem_addr applied
//  busy         out  1       1 in BUSY or DONE
//  grant_data   out  1       owner of the current transaction: 1 = data, 0 = fetch
// BEHAVIOUR
//  Reset (rst_b low, async):
//   - state=IDLE; starve_cnt=0; lat_cnt=0.
//   - All outputs 0: acks, mem_write_en, busy, grant_data, mem_addr, mem_wdata, rdata regs.
//   - Reset mid-transaction aborts it: no ack; mem_write_en drops immediately.
//  FSM IDLE -> BUSY -> DONE -> IDLE. Requests are sampled only in IDLE.
//  IDLE:
//   - No request: stay in IDLE.
//   - One request: grant it.
//   - Both requesting: grant data, unless starve_cnt==STARVE_LIMIT; then grant fetch.
//   - On grant, latch addr/we/wdata/owner into regs, load lat_cnt=MEM_LATENCY-1, go to BUSY.
//  BUSY:
//   - mem_addr/mem_wdata driven from the latched regs (stable for the whole BUSY phase).
//   - mem_write_en=1 only in the first BUSY cycle, and only if the latched we=1.
//   - lat_cnt decrements each cycle. At lat_cnt==0: capture mem_rdata into the owner's rdata
//     reg (reads only; rdata holds its old value on writes) and go to DONE.
//  DONE:
//   - Owner's ack=1 for exactly this cycle; the other ack stays 0; next state IDLE.
//   - mem_addr holds its value; mem_write_en=0.
//  Starvation counter (updated at the grant edge):
//   - Data granted while i_req=1: starve_cnt++ (saturates at STARVE_LIMIT).
//   - Fetch granted, or no fetch pending: starve_cnt=0.
//  Timing and throughput:
//   - Request seen in IDLE at edge N -> ack at cycle N+MEM_LATENCY+1.
//   - Back-to-back transactions take MEM_LATENCY+2 cycles each.
//  Requester rules:
//   - Drop req in the cycle after ack unless another transaction is wanted.
//   - req still high in IDLE after ack counts as a new request.
//   - Requests arriving during BUSY/DONE wait; they are never lost or merged.
//  Unaligned addresses are passed through unchanged (alignment is the requester's job).
// TESTING
//  1 Reset: hold rst_b=0 -> all outputs 0, state IDLE. Pulse rst_b low mid-BUSY of a write
//    -> mem_write_en=0 at once, no ack after release.
//  2 Single fetch read, i_addr=0x40, mem returns 0xDEADBEEF, MEM_LATENCY=2
//    -> i_ack high exactly at cycle 3 after the request edge, i_rdata=0xDEADBEEF; d_ack never high.
//  3 Data write d_addr=0x100, d_wdata=0x12345678
//    -> mem_write_en high for exactly one cycle with those addr/data; then d_ack; d_rdata unchanged.
//  4 i_req and d_req asserted together in IDLE -> data served first, then fetch; acks are
//    MEM_LATENCY+2 cycles apart.
//  5 d_req held continuously with i_req=1, STARVE_LIMIT=4 -> 4 data acks, then one i_ack,
//    then data again; starve_cnt back to 0.
//  6 MEM_LATENCY=1 and MEM_LATENCY=5 regressions -> ack latencies of 2 and 6 cycles;
//    mem_addr stable throughout BUSY.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Main-memory port arbiter: fetch vs data-cache, one fixed-latency
// transaction at a time, one-cycle ack with read data to the winner.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_data
);

  localparam int LW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [LW-1:0] LAT_TOP = LW'(MEM_LATENCY - 1);
  localparam logic [SW-1:0] SLIM    = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [LW-1:0]     lat_cnt;
  logic [SW-1:0]     starve_cnt;
  logic              own_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              pick_d;
  logic              grant;

  assign pick_d = d_req & ~(i_req & (starve_cnt == SLIM));
  assign grant  = (state_q == S_IDLE) & (i_req | d_req);

  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign busy       = (state_q != S_IDLE);
  assign grant_data = own_q;

  // State register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state, write strobe on first BUSY cycle, ack in DONE
  always_comb begin
    state_d      = state_q;
    i_ack        = 1'b0;
    d_ack        = 1'b0;
    mem_write_en = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (grant) state_d = S_BUSY;
      end
      S_BUSY: begin
        mem_write_en = we_q & (lat_cnt == LAT_TOP);
        if (lat_cnt == '0) state_d = S_DONE;
      end
      S_DONE: begin
        i_ack   = ~own_q;
        d_ack   = own_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Grant latch, starvation count, latency count, read capture
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      lat_cnt    <= '0;
      starve_cnt <= '0;
      own_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else if (grant) begin
      own_q   <= pick_d;
      we_q    <= pick_d & d_we;
      addr_q  <= pick_d ? d_addr : i_addr;
      if (pick_d) wdata_q <= d_wdata;
      lat_cnt <= LAT_TOP;
      if (pick_d && i_req)
        starve_cnt <= (starve_cnt == SLIM) ? SLIM
                    : starve_cnt + SW'(1);
      else
        starve_cnt <= '0;
    end else if (state_q == S_BUSY) begin
      if (lat_cnt != '0) begin
        lat_cnt <= lat_cnt - LW'(1);
      end else if (!we_q) begin
        if (own_q) d_rdata <= mem_rdata;
        else       i_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed reset/latency checks plus
// randomized traffic scored against a transaction-level model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        we;
  } exp_t;

  task automatic chk(input string nm, input int k,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%h expected=%h", nm, k, act, exp);
    end
  endtask

  task automatic miss(input string nm, input int k);
    checks++;
    failures++;
    $display("FAIL %s dut%0d actual=none expected=ack", nm, k);
  endtask

  function automatic logic [31:0] raddr();
    raddr = {26'd0, 4'($urandom_range(15)), 2'b00};
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g
    localparam int L  = (k == 0) ? 2 : (k == 1) ? 1 : 5;
    localparam int SL = 4;

    logic        rst_b, i_req, d_req, d_we;
    logic        i_ack, d_ack, mem_write_en, busy, grant_data;
    logic [31:0] i_addr, d_addr, d_wdata, i_rdata, d_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] mem [16];
    logic [31:0] rm  [16];
    exp_t        iq[$];
    exp_t        dq[$];
    exp_t        ge, me;
    int          cyc = 0, idle_at = 0, starve = 0, wcnt = 0;
    logic        en = 1'b0, take_d, cur_own = 1'b0;
    logic [31:0] cur_addr = 0, last_d = 0;

    mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32),
      .MEM_LATENCY(L), .STARVE_LIMIT(SL)
    ) dut (
      .clk(clk), .rst_b(rst_b),
      .i_req(i_req), .i_addr(i_addr),
      .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we),
      .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_write_en(mem_write_en), .mem_rdata(mem_rdata),
      .busy(busy), .grant_data(grant_data)
    );

    assign mem_rdata = mem[mem_addr[5:2]];

    // Memory model and transaction-level reference
    always @(posedge clk) begin
      cyc = cyc + 1;
      if (mem_write_en) mem[mem_addr[5:2]] = mem_wdata;
      if (en && cyc >= idle_at && (i_req || d_req)) begin
        take_d  = d_req && !(i_req && starve == SL);
        ge.cyc  = cyc + L;
        idle_at = cyc + L + 2;
        if (take_d) begin
          cur_own  = 1'b1;
          cur_addr = d_addr;
          ge.we    = d_we;
          if (d_we) begin
            rm[d_addr[5:2]] = d_wdata;
            ge.data = last_d;
          end else begin
            ge.data = rm[d_addr[5:2]];
            last_d  = ge.data;
          end
          dq.push_back(ge);
          starve = i_req ? ((starve < SL) ? starve + 1 : SL) : 0;
        end else begin
          cur_own  = 1'b0;
          cur_addr = i_addr;
          ge.we    = 1'b0;
          ge.data  = rm[i_addr[5:2]];
          iq.push_back(ge);
          starve   = 0;
        end
      end
    end

    // Monitor: compare acks against the queued expectations
    always @(negedge clk) begin
      if (en) begin
        if (busy) begin
          chk("mem_addr", k, mem_addr, cur_addr);
          chk("grant_data", k, 32'(grant_data), 32'(cur_own));
        end
        chk("dual_ack", k, 32'(i_ack & d_ack), 0);
        if (i_ack) begin
          if (iq.size() == 0) chk("i_ack_spurious", k, 1, 0);
          else begin
            me = iq.pop_front();
            chk("i_ack_cyc", k, cyc, me.cyc);
            chk("i_rdata", k, i_rdata, me.data);
            chk("i_wen_cnt", k, wcnt, 0);
          end
          wcnt = 0;
        end else if (iq.size() > 0 && cyc > iq[0].cyc) begin
          miss("i_ack_late", k);
          void'(iq.pop_front());
        end
        if (d_ack) begin
          if (dq.size() == 0) chk("d_ack_spurious", k, 1, 0);
          else begin
            me = dq.pop_front();
            chk("d_ack_cyc", k, cyc, me.cyc);
            chk("d_rdata", k, d_rdata, me.data);
            chk("d_wen_cnt", k, wcnt, 32'(me.we));
          end
          wcnt = 0;
        end else if (dq.size() > 0 && cyc > dq[0].cyc) begin
          miss("d_ack_late", k);
          void'(dq.pop_front());
        end
        if (mem_write_en) wcnt = wcnt + 1;
      end
    end

    // Directed checks, then randomized requesters
    initial begin : stim
      int n, other, wen, keep;
      logic [31:0] prev;
      rst_b = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      i_addr = 0; d_addr = 0; d_wdata = 0;
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      repeat (3) @(negedge clk);
      chk("rst_ctl", k,
          {27'd0, i_ack, d_ack, mem_write_en, busy, grant_data}, 0);
      chk("rst_maddr", k, mem_addr, 0);
      chk("rst_mwdata", k, mem_wdata, 0);
      chk("rst_irdata", k, i_rdata, 0);
      chk("rst_drdata", k, d_rdata, 0);
      rst_b = 1'b1;
      @(negedge clk);

      mem[0] = 32'hDEADBEEF;
      i_addr = 32'h40;
      i_req  = 1'b1;
      n = 0; other = 0;
      while (n < L + 6 && !i_ack) begin
        @(negedge clk);
        n++;
        other += int'(d_ack);
        if (busy && !i_ack) chk("fetch_maddr", k, mem_addr, 32'h40);
      end
      chk("fetch_lat", k, n, L + 1);
      chk("fetch_rdata", k, i_rdata, 32'hDEADBEEF);
      chk("fetch_no_dack", k, other, 0);
      i_req = 1'b0;
      @(negedge clk);
      chk("fetch_pulse", k, 32'(i_ack), 0);

      prev = d_rdata;
      d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'h12345678;
      d_req = 1'b1;
      n = 0; wen = 0; other = 0;
      while (n < L + 6 && !d_ack) begin
        @(negedge clk);
        n++;
        if (mem_write_en) begin
          wen++;
          if (mem_addr !== 32'h100 || mem_wdata !== 32'h12345678)
            other++;
        end
      end
      chk("wr_lat", k, n, L + 1);
      chk("wr_strobes", k, wen, 1);
      chk("wr_bus", k, other, 0);
      chk("wr_drdata", k, d_rdata, prev);
      chk("wr_mem", k, mem[0], 32'h12345678);
      d_req = 1'b0; d_we = 1'b0;
      @(negedge clk);

      d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'hA5A5A5A5;
      d_req = 1'b1;
      @(negedge clk);
      chk("abort_wen_pre", k, 32'(mem_write_en), 1);
      #2 rst_b = 1'b0;
      d_req = 1'b0; d_we = 1'b0;
      #1;
      chk("abort_wen", k, 32'(mem_write_en), 0);
      chk("abort_busy", k, 32'(busy), 0);
      @(negedge clk);
      rst_b = 1'b1;
      other = 0;
      repeat (L + 3) begin
        @(negedge clk);
        other += int'(i_ack) + int'(d_ack);
      end
      chk("abort_no_ack", k, other, 0);
      chk("abort_no_write", k, mem[0], 32'h12345678);

      for (int i = 0; i < 16; i++) rm[i] = mem[i];
      en = 1'b1;
      for (int c = 0; c < 1500; c++) begin
        keep = (c < 400) ? 100 : 50;
        @(negedge clk);
        if (i_req) begin
          if (i_ack) begin
            if ($urandom_range(99) < keep) i_addr = raddr();
            else i_req = 1'b0;
          end
        end else if ($urandom_range(99) < 40) begin
          i_req  = 1'b1;
          i_addr = raddr();
        end
        if (d_req) begin
          if (d_ack) begin
            if ($urandom_range(99) < keep) begin
              d_addr  = raddr();
              d_we    = 1'($urandom_range(1));
              d_wdata = $urandom;
            end else d_req = 1'b0;
          end
        end else if ($urandom_range(99) < 40) begin
          d_req   = 1'b1;
          d_addr  = raddr();
          d_we    = 1'($urandom_range(1));
          d_wdata = $urandom;
        end
      end
      n = 0;
      while (n < 80 &&
             (i_req || d_req || iq.size() > 0 || dq.size() > 0)) begin
        @(negedge clk);
        n++;
        if (i_ack) i_req = 1'b0;
        if (d_ack) d_req = 1'b0;
      end
      chk("drain", k,
          iq.size() + dq.size() + int'(i_req) + int'(d_req), 0);
      done_cnt++;
    end
  end

  initial begin : finisher
    int t;
    t = 0;
    while (done_cnt < 3 && t < 40000) begin
      @(posedge clk);
      t++;
    end
    if (done_cnt < 3) miss("run_timeout", -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
